// File: rtl/alu_issue.sv
// Single-issue ALU sequencer: IDLE -> OPER -> EXEC -> WB, with a register file.
// ALU_ISSUE_R0_ZERO_EN makes register 0 a hardwired zero; by default it is an ordinary register.
module alu_issue #(
  parameter int data_width     = 32,
  parameter int reg_addr_width = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [4:0]                instr_func,
  input  logic [reg_addr_width-1:0] instr_rd,
  input  logic [reg_addr_width-1:0] instr_rs1,
  input  logic [reg_addr_width-1:0] instr_rs2,
  input  logic                      instr_imm_sel,
  input  logic [data_width-1:0]     instr_imm,
  output logic                      alu_en,
  output logic [4:0]                alu_func,
  output logic [data_width-1:0]     alu_S1,
  output logic [data_width-1:0]     alu_S2,
  input  logic [data_width-1:0]     alu_D,
  output logic                      done,
  output logic [reg_addr_width-1:0] done_rd,
  output logic [data_width-1:0]     done_data,
  output logic                      illegal,
  input  logic [reg_addr_width-1:0] dbg_addr,
  output logic [data_width-1:0]     dbg_data,
  output logic [1:0]                dbg_state
);
  localparam int nregs   = 1 << reg_addr_width;
  localparam int shamt_w = $clog2(data_width);

  typedef enum logic [1:0] {IDLE, OPER, EXEC, WB} state_t;

  state_t state, state_nxt;

  logic [4:0]                func_q;
  logic [reg_addr_width-1:0] rd_q, rs1_q, rs2_q;
  logic                      imm_sel_q;
  logic [data_width-1:0]     imm_q;
  logic [data_width-1:0]     s1_q, s2_q, result_q;
  logic [data_width-1:0]     rf [nregs];

  logic                      func_legal, func_shift, rf_we;
  logic [data_width-1:0]     rs1_val, rs2_val, s2_sel, shamt_mask;

  assign shamt_mask = {{(data_width-shamt_w){1'b0}}, {shamt_w{1'b1}}};
  assign func_legal = (func_q >= 5'b01_100) && (func_q <= 5'b11_000);
  assign func_shift = (func_q >= 5'b10_110) && (func_q <= 5'b11_000);

  // Register-file reads; with the zero-register option, address 0 always reads 0.
  always_comb begin
    rs1_val  = rf[rs1_q];
    rs2_val  = rf[rs2_q];
    dbg_data = rf[dbg_addr];
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (rs1_q == '0)    rs1_val  = '0;
    if (rs2_q == '0)    rs2_val  = '0;
    if (dbg_addr == '0) dbg_data = '0;
`endif
  end

  always_comb begin
    s2_sel = imm_sel_q ? imm_q : rs2_val;
    if (func_shift) s2_sel = s2_sel & shamt_mask;
  end

  always_comb begin
    rf_we = (state == WB) && func_legal;
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (rd_q == '0) rf_we = 1'b0;
`endif
  end

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE, and offers made while busy are dropped, not buffered.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = OPER;
      OPER:    state_nxt = func_legal ? EXEC : WB;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_q    <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      result_q  <= '0;
      for (int i = 0; i < nregs; i++) rf[i] <= '0;
    end else begin
      if (state == IDLE && instr_valid) begin
        func_q    <= instr_func;
        rd_q      <= instr_rd;
        rs1_q     <= instr_rs1;
        rs2_q     <= instr_rs2;
        imm_sel_q <= instr_imm_sel;
        imm_q     <= instr_imm;
      end
      if (state == OPER) begin
        s1_q <= rs1_val;
        s2_q <= s2_sel;
      end
      if (state == EXEC) result_q <= alu_D;
      if (rf_we) rf[rd_q] <= result_q;
    end
  end

  always_comb begin
    instr_ready = (state == IDLE);
    alu_en      = (state == EXEC);
    alu_func    = alu_en ? func_q : '0;
    alu_S1      = alu_en ? s1_q : '0;
    alu_S2      = alu_en ? s2_q : '0;
    done        = (state == WB);
    illegal     = done && !func_legal;
    done_rd     = done ? rd_q : '0;
    done_data   = (done && func_legal) ? result_q : '0;
    dbg_state   = state;
  end
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus random instructions against a register-file model.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready;
  logic [4:0]  instr_func;
  logic [3:0]  instr_rd, instr_rs1, instr_rs2;
  logic        instr_imm_sel;
  logic [31:0] instr_imm;
  logic        alu_en;
  logic [4:0]  alu_func;
  logic [31:0] alu_S1, alu_S2, alu_D;
  logic        done, illegal;
  logic [3:0]  done_rd, dbg_addr;
  logic [31:0] done_data, dbg_data;
  logic [1:0]  dbg_state;

`ifdef ALU_ISSUE_R0_ZERO_EN
  localparam bit r0_en = 1'b1;
`else
  localparam bit r0_en = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rf_m [16];
  logic [31:0] exp_q [$];

  alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_func(instr_func), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm_sel(instr_imm_sel), .instr_imm(instr_imm), .alu_en(alu_en), .alu_func(alu_func),
    .alu_S1(alu_S1), .alu_S2(alu_S2), .alu_D(alu_D), .done(done), .done_rd(done_rd),
    .done_data(done_data), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 12 ADD, 13 ADDF, 14 SUB, 15 SUBF, 16 AND, 17 OR, 18 XOR,
  // 19 SLT, 20 SLTU, 21 NOR, 22 SRL, 23 SRA, 24 SLL.
  function automatic logic [31:0] alu_model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      5'd12:   return a + b;
      5'd14:   return a - b;
      5'd16:   return a & b;
      5'd17:   return a | b;
      5'd18:   return a ^ b;
      5'd19:   return {31'b0, $signed(a) < $signed(b)};
      5'd20:   return {31'b0, a < b};
      5'd21:   return ~(a | b);
      5'd22:   return a >> b;
      5'd23:   return 32'($signed(a) >>> b);
      5'd24:   return a << b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_D = alu_model(alu_func, alu_S1, alu_S2);

  function automatic logic [31:0] rd_m(input logic [3:0] a);
    return (r0_en && a == 4'd0) ? 32'd0 : rf_m[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_garbage();
    instr_valid   = 1'b1;
    instr_func    = 5'($urandom_range(0, 31));
    instr_rd      = 4'($urandom_range(0, 15));
    instr_rs1     = 4'($urandom_range(0, 15));
    instr_rs2     = 4'($urandom_range(0, 15));
    instr_imm_sel = 1'($urandom_range(0, 1));
    instr_imm     = $urandom;
  endtask

  // Issues one instruction and checks every cycle up to retirement against the model.
  task automatic issue(input logic [4:0] f, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic isel, input logic [31:0] imm,
                       input bit abort_exec);
    logic [31:0] a, b, exp;
    bit legal, shift;
    int done_k;
    legal = (f >= 5'd12) && (f <= 5'd24);
    shift = (f >= 5'd22) && (f <= 5'd24);
    a = rd_m(rs1);
    b = isel ? imm : rd_m(rs2);
    if (shift) b = b % 32;
    exp = legal ? alu_model(f, a, b) : 32'd0;
    done_k = legal ? 3 : 2;
    @(negedge clk);
    check("ready_before_issue", {31'b0, instr_ready}, 32'd1);
    instr_valid = 1'b1; instr_func = f; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_imm_sel = isel; instr_imm = imm;
    exp_q.push_back(exp);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("alu_en", {31'b0, alu_en}, {31'b0, legal && k == 2});
      if (legal && k == 2) begin
        check("alu_func", {27'b0, alu_func}, {27'b0, f});
        check("alu_s1", alu_S1, a);
        check("alu_s2", alu_S2, b);
      end else begin
        check("alu_ops_idle", alu_S1 | alu_S2 | {27'b0, alu_func}, 32'd0);
      end
      check("done", {31'b0, done}, {31'b0, k == done_k});
      check("illegal", {31'b0, illegal}, {31'b0, k == done_k && !legal});
      check("ready_busy", {31'b0, instr_ready}, {31'b0, k > done_k});
      if (k == done_k) begin
        check("done_rd", {28'b0, done_rd}, {28'b0, rd});
        check("done_data", done_data, exp_q.pop_front());
      end
      if (abort_exec && k == 2) begin
        rst = 1'b1;
        #1;
        check("abort_alu_en", {31'b0, alu_en}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        for (int i = 0; i < 16; i++) rf_m[i] = 32'd0;
        exp_q.delete();
        instr_valid = 1'b0;
        return;
      end
      if (k < 3 || legal) drive_garbage();
      else instr_valid = 1'b0;
    end
    if (legal && !(r0_en && rd == 4'd0)) rf_m[rd] = exp;
  endtask

  task automatic check_rf(input string tag);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check(tag, dbg_data, rd_m(4'(i)));
    end
  endtask

  task automatic peek(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    @(negedge clk);
    instr_valid = 1'b0;
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_func = '0; instr_rd = '0; instr_rs1 = '0;
    instr_rs2 = '0; instr_imm_sel = 1'b0; instr_imm = '0; dbg_addr = '0;
    for (int i = 0; i < 16; i++) rf_m[i] = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_alu_en", {31'b0, alu_en}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check_rf("rst_rf");

    // Subtract of two immediate-seeded registers.
    issue(5'd12, 4'd1, 4'd4, 4'd0, 1'b1, 32'd5, 1'b0);
    issue(5'd12, 4'd2, 4'd4, 4'd0, 1'b1, 32'd3, 1'b0);
    issue(5'd14, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 1'b0);
    peek("sub_rd3", 4'd3, 32'd2);

    // Arithmetic shift with an oversized immediate amount.
    issue(5'd12, 4'd1, 4'd4, 4'd0, 1'b1, 32'h8000_0000, 1'b0);
    issue(5'd23, 4'd5, 4'd1, 4'd0, 1'b1, 32'h24, 1'b0);
    peek("sra_rd5", 4'd5, 32'hF800_0000);

    // Illegal codes at and beyond both edges of the legal range, then legal edges.
    issue(5'd3, 4'd6, 4'd1, 4'd2, 1'b0, 32'd0, 1'b0);
    issue(5'd11, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 1'b0);
    issue(5'd25, 4'd3, 4'd1, 4'd2, 1'b1, 32'd9, 1'b0);
    peek("illegal_no_write", 4'd3, 32'd2);
    issue(5'd24, 4'd9, 4'd2, 4'd0, 1'b1, 32'd33, 1'b0);
    issue(5'd13, 4'd10, 4'd1, 4'd2, 1'b0, 32'd0, 1'b0);
    issue(5'd15, 4'd11, 4'd1, 4'd2, 1'b0, 32'd0, 1'b0);

    // Back-to-back dependent adds and a destination that is also both sources.
    issue(5'd12, 4'd7, 4'd3, 4'd0, 1'b1, 32'd10, 1'b0);
    issue(5'd12, 4'd8, 4'd7, 4'd0, 1'b1, 32'd1, 1'b0);
    issue(5'd12, 4'd8, 4'd8, 4'd8, 1'b0, 32'd0, 1'b0);
    peek("dep_rd8", 4'd8, 32'd26);

    // Write to register 0.
    issue(5'd12, 4'd0, 4'd4, 4'd0, 1'b1, 32'd7, 1'b0);
    peek("r0_value", 4'd0, r0_en ? 32'd0 : 32'd7);

    for (int n = 0; n < 40; n++)
      issue(5'($urandom_range(10, 26)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
    check_rf("rand_rf");

    // Reset while the ALU is enabled.
    issue(5'd12, 4'd12, 4'd1, 4'd2, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check("abort_rf", dbg_data, 32'd0);
    end
    @(negedge clk);
    check("abort_no_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'b0, instr_ready}, 32'd1);
    issue(5'd12, 4'd12, 4'd4, 4'd0, 1'b1, 32'd42, 1'b0);
    peek("post_abort", 4'd12, 32'd42);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter data_width, default 32: width of operands, results and register-file entries.
REQ-002 Parameter reg_addr_width, default 4: register-file address width (16 entries at default).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 instr_valid  input  1  instruction offered this cycle.
REQ-006 instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 instr_func  input  5  ALU function code, same encoding the ALU decodes.
REQ-008 instr_rd, instr_rs1, instr_rs2  input  reg_addr_width each  destination and source register addresses.
REQ-009 instr_imm_sel  input  1  1 = use instr_imm as second operand instead of rs2.
REQ-010 instr_imm  input  data_width  immediate second operand.
REQ-011 alu_en  output  1  enable to the ALU.
REQ-012 alu_func  output  5  function code to the ALU.
REQ-013 alu_S1, alu_S2  output  data_width each  operands to the ALU.
REQ-014 alu_D  input  data_width  combinational ALU result.
REQ-015 done  output  1  one-cycle pulse: instruction retired.
REQ-016 done_rd  output  reg_addr_width  destination of retired instruction; done_data  output  data_width  value written.
REQ-017 illegal  output  1  one-cycle pulse with done when retired func was illegal.
REQ-018 dbg_addr  input  reg_addr_width; dbg_data  output  data_width: asynchronous register-file read port.

Function
REQ-019 The block SHALL implement FSM IDLE -> OPER -> EXEC -> WB -> IDLE; instr_ready SHALL be 1 only in IDLE.
REQ-020 Handshake: an instruction is accepted on the rising edge where instr_valid and instr_ready are both 1; all instr_* fields are latched at that edge; FSM moves to OPER.
REQ-021 OPER: operand registers load S1 = RF[rs1], S2 = instr_imm_sel ? imm : RF[rs2]; shift funcs (10_110, 10_111, 11_000) SHALL mask S2 to its low log2(data_width) bits, upper bits zero.
REQ-022 EXEC: alu_en = 1, alu_func/alu_S1/alu_S2 driven from latched values; alu_D captured into result register at end of EXEC.
REQ-023 alu_en SHALL be 0 in every state other than EXEC; alu_S1, alu_S2, alu_func SHALL be 0 outside EXEC.
REQ-024 WB: RF[rd] = result, done = 1, done_rd/done_data valid for that cycle only; FSM returns to IDLE.
REQ-025 Latency: done asserts exactly 3 cycles after the accepting edge; throughput one instruction per 4 cycles.
REQ-026 Legal funcs: 01_100 to 11_000 inclusive; ADDF/SUBF (01_101, 01_111) legal, result is whatever the ALU returns (0).
REQ-027 Illegal func: OPER -> WB directly, EXEC skipped, alu_en stays 0, no register write, done = 1 and illegal = 1, done_data = 0.
REQ-028 rs1 or rs2 equal to rd SHALL read the pre-write value; a write in WB is visible to the next accepted instruction's OPER.
REQ-029 instr_valid while not in IDLE SHALL be ignored; no buffering.
REQ-030 dbg_data = RF[dbg_addr] combinationally, reflecting writes from the following cycle.

Reset
REQ-031 rst SHALL immediately force FSM to IDLE, all register-file entries, operand, result and latched fields to 0; done, illegal, alu_en to 0; instr_ready to 1 after rst deasserts.
REQ-032 Reset in any state SHALL abort the instruction in flight with no write and no done pulse.

Configuration
REQ-033 Macro ALU_ISSUE_R0_ZERO_EN defined: RF[0] reads 0 always and writes to register 0 are discarded (done still pulses with done_data = computed result); undefined: register 0 is an ordinary register.

Verification
REQ-034 Reset, then RF[1]=5, RF[2]=3 via prior imm adds; issue func 01_110 rd=3 rs1=1 rs2=2 -> done 3 cycles later, done_data=2, dbg RF[3]=2.
REQ-035 RF[1]=0x80000000; issue 10_111 rs1=1 imm_sel=1 imm=0x24 -> S2 masked to 4, done_data=0xF8000000.
REQ-036 Issue func 00_011 -> EXEC skipped, alu_en never 1, done and illegal pulse 2 cycles after accept, RF unchanged.
REQ-037 Back-to-back: instr_valid held high with two adds, second depends on first's rd -> second accepted 4 cycles after first, uses written value.
REQ-038 Assert rst during EXEC -> no done pulse, alu_en drops same cycle, all RF reads 0, instr_ready=1 next cycle.
REQ-039 With ALU_ISSUE_R0_ZERO_EN: add imm 7 to rd=0 -> done_data=7, dbg RF[0]=0; without macro dbg RF[0]=7.
